// File: rtl/shift_sequencer.sv
// Multi-step driver around the combinational shift_reg: accepts one job per handshake,
// loops the word through shift_reg once per clock, and holds the result until it is taken.
module shift_sequencer #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [CNT_W-1:0]      in_count,
    input  logic                  in_mode,
    input  logic                  in_direction,
    input  logic [(2**CNT_W)-1:0] in_serial,
    output logic [WIDTH-1:0]      sr_datain,
    output logic                  sr_mode,
    output logic                  sr_direction,
    output logic                  sr_serial_in,
    input  logic [WIDTH-1:0]      sr_dataout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  busy
);

    localparam int SER_W = 2 ** CNT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   work_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   step_q;
    logic               mode_q;
    logic               dir_q;
    logic [SER_W-1:0]   serial_q;

    logic               accept;
    logic               advance;
    logic               last_step;

    assign last_step = (step_q == (count_q - CNT_W'(1)));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        advance   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = (in_count == '0) ? HOLD : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                advance = 1'b1;
                if (last_step) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // The acceptance cycle returns to IDLE only; a new job waits one more cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            count_q  <= '0;
            step_q   <= '0;
            mode_q   <= 1'b0;
            dir_q    <= 1'b0;
            serial_q <= '0;
        end else if (accept) begin
            work_q   <= in_data;
            count_q  <= in_count;
            step_q   <= '0;
            mode_q   <= in_mode;
            dir_q    <= in_direction;
            serial_q <= in_serial;
        end else if (advance) begin
            work_q <= sr_dataout;
            // Parks at count-1 on the final step so the index never runs past the job.
            if (!last_step) begin
                step_q <= step_q + CNT_W'(1);
            end
        end
    end

    assign sr_datain    = work_q;
    assign sr_mode      = mode_q;
    assign sr_direction = dir_q;
    assign sr_serial_in = (state_q == RUN) ? serial_q[step_q] : 1'b0;
    assign out_data     = work_q;

    step_in_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == RUN) |-> (step_q < count_q)
    );

    hold_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == HOLD && !out_ready) |=> (state_q == HOLD && $stable(work_q))
    );

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; a behavioural shift_reg closes the datapath loop.
module tb_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic [2:0] in_count;
    logic       in_mode;
    logic       in_direction;
    logic [7:0] in_serial;
    logic [5:0] sr_datain;
    logic       sr_mode;
    logic       sr_direction;
    logic       sr_serial_in;
    logic [5:0] sr_dataout;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    shift_sequencer #(.WIDTH(6), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_count     (in_count),
        .in_mode      (in_mode),
        .in_direction (in_direction),
        .in_serial    (in_serial),
        .sr_datain    (sr_datain),
        .sr_mode      (sr_mode),
        .sr_direction (sr_direction),
        .sr_serial_in (sr_serial_in),
        .sr_dataout   (sr_dataout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    // Combinational shift_reg: mode 1 = rotate, direction 1 = left.
    always_comb begin
        if (sr_mode) begin
            sr_dataout = sr_direction ? {sr_datain[4:0], sr_datain[5]} : {sr_datain[0], sr_datain[5:1]};
        end else begin
            sr_dataout = sr_direction ? {sr_datain[4:0], sr_serial_in} : {sr_serial_in, sr_datain[5:1]};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_job(input logic [5:0] d, input logic [2:0] c, input logic m,
                             input logic dir, input logic [7:0] s);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_count = c; in_mode = m; in_direction = dir; in_serial = s;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic take_result;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 6'b000000) begin errors++; $display("FAIL reset_out_data: got %b expected 000000", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (sr_serial_in !== 1'b0 || sr_datain !== 6'b000000) begin errors++; $display("FAIL reset_sr: got serial %b datain %b expected 0 000000", sr_serial_in, sr_datain); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got in_ready %b busy %b expected 1 0", in_ready, busy); end
    endtask

    task automatic test_rotate_count1;
        int e;
        start_job(6'b100001, 3'd1, 1'b1, 1'b1, 8'h00);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rot1_run_flags: got busy %b in_ready %b out_valid %b expected 1 0 0", busy, in_ready, out_valid); end
        wait_valid(e);
        checks++; if (e != 1) begin errors++; $display("FAIL rot1_latency: got %0d edges expected 1", e); end
        checks++; if (out_data !== 6'b000011) begin errors++; $display("FAIL rot1_data: got %b expected 000011", out_data); end
        take_result();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rot1_release: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready); end
    endtask

    task automatic test_full_wrap;
        int e;
        start_job(6'b101100, 3'd6, 1'b1, 1'b1, 8'h00);
        wait_valid(e);
        checks++; if (e != 6) begin errors++; $display("FAIL wrap_latency: got %0d edges expected 6", e); end
        checks++; if (out_data !== 6'b101100) begin errors++; $display("FAIL wrap_data: got %b expected 101100", out_data); end
        take_result();
    endtask

    task automatic test_shift_right;
        start_job(6'b111000, 3'd3, 1'b0, 1'b0, 8'b00000101);
        checks++; if (sr_datain !== 6'b111000 || sr_serial_in !== 1'b1) begin errors++; $display("FAIL shr_step0: got %b/%b expected 111000/1", sr_datain, sr_serial_in); end
        @(negedge clk);
        checks++; if (sr_datain !== 6'b111100 || sr_serial_in !== 1'b0) begin errors++; $display("FAIL shr_step1: got %b/%b expected 111100/0", sr_datain, sr_serial_in); end
        @(negedge clk);
        checks++; if (sr_datain !== 6'b011110 || sr_serial_in !== 1'b1) begin errors++; $display("FAIL shr_step2: got %b/%b expected 011110/1", sr_datain, sr_serial_in); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 6'b101111) begin errors++; $display("FAIL shr_result: got valid %b data %b expected 1 101111", out_valid, out_data); end
        checks++; if (sr_serial_in !== 1'b0) begin errors++; $display("FAIL shr_hold_serial: got %b expected 0", sr_serial_in); end
        take_result();
    endtask

    task automatic test_serial_ignored;
        int e;
        start_job(6'b000001, 3'd2, 1'b1, 1'b0, 8'hFF);
        wait_valid(e);
        checks++; if (e != 2 || out_data !== 6'b010000) begin errors++; $display("FAIL rotr_serial: got %0d edges data %b expected 2 010000", e, out_data); end
        take_result();
        start_job(6'b000111, 3'd2, 1'b0, 1'b1, 8'b11111110);
        wait_valid(e);
        checks++; if (e != 2 || out_data !== 6'b011101) begin errors++; $display("FAIL shl_upper_serial: got %0d edges data %b expected 2 011101", e, out_data); end
        take_result();
    endtask

    task automatic test_count_zero;
        int e;
        start_job(6'b010101, 3'd0, 1'b0, 1'b0, 8'hFF);
        wait_valid(e);
        checks++; if (e != 0) begin errors++; $display("FAIL cnt0_latency: got %0d edges expected 0", e); end
        checks++; if (out_data !== 6'b010101 || sr_serial_in !== 1'b0) begin errors++; $display("FAIL cnt0_data: got %b serial %b expected 010101 0", out_data, sr_serial_in); end
        take_result();
    endtask

    task automatic test_hold_stall;
        int e;
        int bad;
        start_job(6'b000010, 3'd1, 1'b1, 1'b1, 8'h00);
        wait_valid(e);
        checks++; if (out_data !== 6'b000100) begin errors++; $display("FAIL stall_first: got %b expected 000100", out_data); end
        in_valid = 1'b1; in_data = 6'b000001; in_count = 3'd1; in_mode = 1'b1; in_direction = 1'b1; in_serial = 8'h00;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_data !== 6'b000100 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_accept_cycle: got valid %b ready %b busy %b expected 0 1 0", out_valid, in_ready, busy); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_second_accept: got busy %b expected 1", busy); end
        wait_valid(e);
        checks++; if (e != 1 || out_data !== 6'b000010) begin errors++; $display("FAIL stall_second_data: got %0d edges data %b expected 1 000010", e, out_data); end
        take_result();
    endtask

    task automatic test_idle_out_ready;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_out_ready: got valid %b ready %b busy %b expected 0 1 0", out_valid, in_ready, busy); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int seen;
        start_job(6'b000001, 3'd5, 1'b1, 1'b1, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checks++; if (sr_datain !== 6'b000100 || busy !== 1'b1) begin errors++; $display("FAIL midrun_step2: got %b busy %b expected 000100 1", sr_datain, busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_flags: got valid %b ready %b busy %b expected 0 1 0", out_valid, in_ready, busy); end
        checks++; if (out_data !== 6'b000000) begin errors++; $display("FAIL midrun_reset_data: got %b expected 000000", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrun_no_result: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_back_to_back;
        int e;
        start_job(6'b000010, 3'd1, 1'b1, 1'b0, 8'h00);
        wait_valid(e);
        checks++; if (e != 1 || out_data !== 6'b000001) begin errors++; $display("FAIL b2b_first: got %0d edges data %b expected 1 000001", e, out_data); end
        take_result();
        start_job(6'b000001, 3'd4, 1'b0, 1'b1, 8'b00001010);
        wait_valid(e);
        checks++; if (e != 4 || out_data !== 6'b010101) begin errors++; $display("FAIL b2b_second: got %0d edges data %b expected 4 010101", e, out_data); end
        take_result();
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_count     = '0;
        in_mode      = 1'b0;
        in_direction = 1'b0;
        in_serial    = '0;
        out_ready    = 1'b0;
        test_reset();
        test_rotate_count1();
        test_full_wrap();
        test_shift_right();
        test_serial_ignored();
        test_count_zero();
        test_hold_stall();
        test_idle_out_ready();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
